// File: rtl/arduino_comm_pkg.sv
// Shared types and constants for the Arduino coordinate link receiver.
// COORD_CLAMP_EN (see arduino_coord_rx) uses the screen bounds defined here.
package arduino_comm_pkg;

  localparam int DATA_W_DEFAULT = 10;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  // Strobe edge polarity: rising edge carries X, falling edge carries Y.
  localparam logic POL_X = 1'b0;
  localparam logic POL_Y = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE
  } rx_state_t;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-bit, STAGES-deep flop chain bringing asynchronous GPIO pins into clk.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its predecessor's old value.
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/arduino_coord_rx.sv
// Arduino X/Y coordinate receiver: sync, settle-validated strobe edges, atomic pair commit.
// Define COORD_CLAMP_EN to clamp committed coordinates to the X_MAX/Y_MAX screen bounds.
module arduino_coord_rx
  import arduino_comm_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ERR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpio_data,
  input  logic              gpio_strobe,
  output logic [DATA_W-1:0] x_coord,
  output logic [DATA_W-1:0] y_coord,
  output logic              coord_valid,
  output logic              link_alive,
  output logic [ERR_W-1:0]  err_count
);

  localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SC_W-1:0]   SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX     = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_DONE   = WARM_W'(SYNC_STAGES + 1);

  logic              strobe_s, strobe_d;
  logic [DATA_W-1:0] data_s;

  gpio_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk(clk), .reset(reset), .d(gpio_strobe), .q(strobe_s)
  );

  gpio_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_data_sync (
    .clk(clk), .reset(reset), .d(gpio_data), .q(data_s)
  );

  // Pin levels present at reset are a baseline, not edges: hold off edge
  // detection until the synchroniser and the edge register have filled.
  logic [WARM_W-1:0] warm_cnt;
  logic              edge_en, rise, fall;

  assign edge_en = (warm_cnt == WARM_DONE);
  assign rise    = edge_en &  strobe_s & ~strobe_d;
  assign fall    = edge_en & ~strobe_s &  strobe_d;

  rx_state_t       state, state_n;
  logic [SC_W-1:0] settle_cnt, settle_cnt_n;
  logic            pol, pol_n;
  logic            glitch;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_n      = state;
    settle_cnt_n = settle_cnt;
    pol_n        = pol;
    glitch       = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise || fall) begin
          state_n      = SETTLE;
          pol_n        = fall ? POL_Y : POL_X;
          settle_cnt_n = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if ((pol == POL_X) ? fall : rise) begin
          glitch  = 1'b1;
          state_n = IDLE;
        end else if (settle_cnt == '0) begin
          state_n = CAPTURE;
        end else begin
          settle_cnt_n = settle_cnt - 1'b1;
        end
      end
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic              have_x;
  logic [DATA_W-1:0] x_hold;
  logic              cap_x, cap_y, commit, orphan;
  logic [DATA_W-1:0] x_commit, y_commit;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;

  assign cap_x  = (state == CAPTURE) && (pol == POL_X);
  assign cap_y  = (state == CAPTURE) && (pol == POL_Y);
  assign commit = cap_y &  have_x;
  assign orphan = cap_y & ~have_x;

  always_comb begin
`ifdef COORD_CLAMP_EN
    x_commit = (int'(x_hold) > X_MAX) ? DATA_W'(X_MAX) : x_hold;
    y_commit = (int'(data_s) > Y_MAX) ? DATA_W'(Y_MAX) : data_s;
`else
    x_commit = x_hold;
    y_commit = data_s;
`endif
  end

  always_comb begin
    tmo_cnt_n = tmo_cnt;
    if (commit)                tmo_cnt_n = '0;
    else if (tmo_cnt != TMO_MAX) tmo_cnt_n = tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      pol         <= POL_X;
      strobe_d    <= 1'b0;
      warm_cnt    <= '0;
      have_x      <= 1'b0;
      x_hold      <= '0;
      x_coord     <= '0;
      y_coord     <= '0;
      coord_valid <= 1'b0;
      link_alive  <= 1'b0;
      err_count   <= '0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_cnt_n;
      pol         <= pol_n;
      strobe_d    <= strobe_s;
      if (!edge_en) warm_cnt <= warm_cnt + 1'b1;
      coord_valid <= commit;
      tmo_cnt     <= tmo_cnt_n;

      if (cap_x) begin
        x_hold <= data_s;
        have_x <= 1'b1;
      end else if (commit) begin
        have_x <= 1'b0;
      end

      if (commit) begin
        x_coord <= x_commit;
        y_coord <= y_commit;
      end

      if (commit)                   link_alive <= 1'b1;
      else if (tmo_cnt_n == TMO_MAX) link_alive <= 1'b0;

      if ((glitch || orphan) && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule
